// File: rtl/ahb_interconnect_if.sv
// ahb_interconnect_if: AHB-Lite bus bundle between one master, the interconnect and N slaves
//  Master side : HADDR, HTRANS, HWRITE (to interconnect/slaves), HRDATA, HREADY, HRESP (to master)
//  Slave side  : S_HSEL (to slaves), S_HRDATA, S_HREADYOUT, S_HRESP (from slaves), slave i at [i] / [32*i+:32]
//  modport slave  : the interconnect's view
//  modport master : the view of whatever drives the master side and models the slaves
interface ahb_interconnect_if #(parameter int N = 4);
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic            HWRITE;
  logic [31:0]     HRDATA;
  logic            HREADY;
  logic            HRESP;
  logic [N-1:0]    S_HSEL;
  logic [N*32-1:0] S_HRDATA;
  logic [N-1:0]    S_HREADYOUT;
  logic [N-1:0]    S_HRESP;
  modport slave (
    input  HADDR, HTRANS, HWRITE, S_HRDATA, S_HREADYOUT, S_HRESP,
    output HRDATA, HREADY, HRESP, S_HSEL
  );
  modport master (
    output HADDR, HTRANS, HWRITE, S_HRDATA, S_HREADYOUT, S_HRESP,
    input  HRDATA, HREADY, HRESP, S_HSEL
  );
endinterface

// File: rtl/ahb_interconnect.sv
// ahb_interconnect: AHB-Lite single-master decoder, data-phase response mux and default slave
//  Ports:
//   HCLK        in   bus clock
//   HRESETn     in   asynchronous reset, active low
//   bus         ahb_interconnect_if.slave (master address/control in, response out, slave selects/responses)
//   timeout_stb out  one-cycle pulse when a stalled slave is aborted (0 when timeout support is off)
//  Optional feature: define AHB_INTERCONNECT_TIMEOUT_EN to enable the slave stall timeout.
module ahb_interconnect #(
  parameter int                        SLAVE_COUNT    = 4,
  parameter logic [SLAVE_COUNT*32-1:0] ADDR_BASE      = {32'h3000, 32'h2000, 32'h1000, 32'h0},
  parameter logic [SLAVE_COUNT*32-1:0] ADDR_MASK      = {4{32'hFFFF_F000}},
  parameter int                        TIMEOUT_CYCLES = 256
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  ahb_interconnect_if.slave        bus,
  output logic                     timeout_stb
);
  typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} state_t;
  if (SLAVE_COUNT < 1 || SLAVE_COUNT > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("ahb_interconnect: SLAVE_COUNT must be 1..16 and TIMEOUT_CYCLES >= 2");
  end
  state_t                 r_state;
  logic [SLAVE_COUNT-1:0] r_sel;
  logic                   r_def;
  logic [SLAVE_COUNT-1:0] w_hit;
  logic [SLAVE_COUNT-1:0] w_dec;
  logic [SLAVE_COUNT-1:0] w_stalled;
  logic [SLAVE_COUNT-1:0] w_load_sel;
  logic [31:0]            w_s_rdata;
  logic                   w_s_rdy;
  logic                   w_s_resp;
  logic                   w_err_req;
  logic                   w_timeout;
  for (genvar i = 0; i < SLAVE_COUNT; i++) begin : g_hit
    assign w_hit[i] = (bus.HADDR & ADDR_MASK[32*i+:32]) == ADDR_BASE[32*i+:32];
  end
  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_dec = '0;
    for (int i = SLAVE_COUNT-1; i >= 0; i--) if (w_hit[i]) w_dec = SLAVE_COUNT'(1) << i;
  end
  assign bus.S_HSEL = w_dec;
  // A stalled slave is never handed a data phase; active transfers to it error out instead.
  assign w_load_sel = w_dec & ~w_stalled;
  assign w_err_req  = bus.HTRANS[1] && (w_load_sel == '0);
  always_comb begin
    w_s_rdata = '0;
    w_s_rdy   = 1'b1;
    w_s_resp  = 1'b0;
    for (int i = 0; i < SLAVE_COUNT; i++) if (r_sel[i]) begin
      w_s_rdata = bus.S_HRDATA[32*i+:32];
      w_s_rdy   = bus.S_HREADYOUT[i];
      w_s_resp  = bus.S_HRESP[i];
    end
  end
  assign bus.HREADY = r_def ? (r_state != ST_ERR1) : w_s_rdy;
  assign bus.HRESP  = r_def ? (r_state != ST_OK) : w_s_resp;
  assign bus.HRDATA = r_def ? '0 : w_s_rdata;
`ifdef AHB_INTERCONNECT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0]          r_cnt;
  logic [SLAVE_COUNT-1:0] r_stalled;
  logic                   r_stb;
  logic                   w_stall_now;
  assign w_stall_now = !r_def && !w_s_rdy;
  assign w_timeout   = w_stall_now && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_stalled   = r_stalled;
  assign timeout_stb = r_stb;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt     <= '0;
      r_stalled <= '0;
      r_stb     <= 1'b0;
    end else begin
      r_stb     <= w_timeout;
      r_cnt     <= (w_timeout || !w_stall_now) ? '0 : r_cnt + 1'b1;
      r_stalled <= (r_stalled | (w_timeout ? r_sel : '0)) & ~bus.S_HREADYOUT;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign w_stalled   = '0;
  assign timeout_stb = 1'b0;
`endif
  // A timeout hijacks the data phase into the default slave's two-cycle ERROR.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_OK;
      r_sel   <= '0;
      r_def   <= 1'b1;
    end else if (w_timeout) begin
      r_state <= ST_ERR1;
      r_sel   <= '0;
      r_def   <= 1'b1;
    end else if (r_state == ST_ERR1) begin
      r_state <= ST_ERR2;
    end else if (bus.HREADY) begin
      r_state <= w_err_req ? ST_ERR1 : ST_OK;
      r_sel   <= w_err_req ? '0 : w_load_sel;
      r_def   <= w_err_req || (w_load_sel == '0);
    end
  end
endmodule

// File: tb/tb_ahb_interconnect.sv
// tb_ahb_interconnect: directed self-checking bench for ahb_interconnect
module tb_ahb_interconnect;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic timeout_stb;
  int   n_cmp = 0;
  int   n_bad = 0;
  ahb_interconnect_if #(.N(4)) bus ();
  ahb_interconnect #(.SLAVE_COUNT(4), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus.slave), .timeout_stb(timeout_stb)
  );
  always #5 HCLK = ~HCLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rsp(input string tag, input logic rdy, input logic resp);
    chk({tag, ".HREADY"}, 32'(bus.HREADY), 32'(rdy));
    chk({tag, ".HRESP"}, 32'(bus.HRESP), 32'(resp));
  endtask
  task automatic cyc(input logic [31:0] a, input logic [1:0] t);
    @(posedge HCLK);
    #1;
    bus.HADDR  = a;
    bus.HTRANS = t;
    @(negedge HCLK);
  endtask
  initial begin
    bus.HADDR = 32'h0; bus.HTRANS = IDLE; bus.HWRITE = 1'b0;
    bus.S_HRDATA = '0; bus.S_HREADYOUT = 4'hF; bus.S_HRESP = 4'h0;
    // 1 reset
    @(negedge HCLK);
    rsp("reset", 1'b1, 1'b0);
    chk("reset.HRDATA", bus.HRDATA, 32'h0);
    chk("reset.stb", 32'(timeout_stb), 32'h0);
    chk("reset.HSEL", 32'(bus.S_HSEL), 32'h1);
    @(posedge HCLK); #1; HRESETn = 1'b1;
    cyc(32'h0, IDLE);
    chk("idle0.HSEL", 32'(bus.S_HSEL), 32'h1);
    rsp("idle0", 1'b1, 1'b0);
    // 2 zero-wait read from slave2
    bus.S_HRDATA[64+:32] = 32'hCAFE_F00D;
    cyc(32'h2004, NONSEQ);
    chk("rd2.HSEL", 32'(bus.S_HSEL), 32'h4);
    cyc(32'h0, IDLE);
    chk("rd2.HRDATA", bus.HRDATA, 32'hCAFE_F00D);
    rsp("rd2", 1'b1, 1'b0);
    // 3 unmapped active -> two-cycle ERROR
    cyc(32'h8000, NONSEQ);
    chk("unm.HSEL", 32'(bus.S_HSEL), 32'h0);
    cyc(32'h0, IDLE);
    rsp("unm.err1", 1'b0, 1'b1);
    chk("unm.HRDATA", bus.HRDATA, 32'h0);
    cyc(32'h0, IDLE);
    rsp("unm.err2", 1'b1, 1'b1);
    cyc(32'h0, IDLE);
    rsp("unm.ok", 1'b1, 1'b0);
    // unmapped IDLE -> OKAY, no wait
    cyc(32'h8000, IDLE);
    cyc(32'h0, IDLE);
    rsp("unm_idle", 1'b1, 1'b0);
    // 4 slave1 write with 3 wait states, next address held
    bus.HWRITE = 1'b1;
    cyc(32'h1000, NONSEQ);
    chk("wr1.HSEL", 32'(bus.S_HSEL), 32'h2);
    bus.HWRITE = 1'b0;
    bus.S_HREADYOUT[1] = 1'b0;
    bus.S_HRDATA[64+:32] = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      cyc(32'h2000, NONSEQ);
      rsp($sformatf("wr1.wait%0d", k), 1'b0, 1'b0);
      chk("wr1.timeout_stb", 32'(timeout_stb), 32'h0);
    end
    bus.S_HREADYOUT[1] = 1'b1;
    cyc(32'h2000, NONSEQ);
    rsp("wr1.done", 1'b1, 1'b0);
    cyc(32'h0, IDLE);
    chk("wr1.next.HRDATA", bus.HRDATA, 32'h1234_5678);
    // 5 back-to-back unmapped, then slave0
    bus.S_HRDATA[0+:32] = 32'hA5A5_0001;
    cyc(32'h8000, NONSEQ);
    cyc(32'h9000, NONSEQ);
    rsp("b2b.err1a", 1'b0, 1'b1);
    cyc(32'h9000, NONSEQ);
    rsp("b2b.err2a", 1'b1, 1'b1);
    cyc(32'h0, NONSEQ);
    rsp("b2b.err1b", 1'b0, 1'b1);
    cyc(32'h0, NONSEQ);
    rsp("b2b.err2b", 1'b1, 1'b1);
    cyc(32'h0, IDLE);
    rsp("b2b.ok", 1'b1, 1'b0);
    chk("b2b.HRDATA", bus.HRDATA, 32'hA5A5_0001);
    // slave ERROR response passes through
    bus.S_HRESP[0] = 1'b1;
    @(negedge HCLK);
    rsp("s0resp", 1'b1, 1'b1);
    bus.S_HRESP[0] = 1'b0;
    // async reset abandons an error in progress
    cyc(32'h8000, NONSEQ);
    cyc(32'h8000, NONSEQ);
    rsp("arst.err1", 1'b0, 1'b1);
    #2 HRESETn = 1'b0;
    #1;
    rsp("arst", 1'b1, 1'b0);
    @(posedge HCLK); #1; HRESETn = 1'b1;
    bus.HTRANS = IDLE; bus.HADDR = 32'h0;
`ifdef AHB_INTERCONNECT_TIMEOUT_EN
    // 6 slave3 hangs -> timeout after 4 stall cycles, stalled slave errors until it recovers
    cyc(32'h3000, NONSEQ);
    bus.S_HREADYOUT[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(32'h0, IDLE);
      rsp($sformatf("to.stall%0d", k), 1'b0, 1'b0);
      chk($sformatf("to.stb_lo%0d", k), 32'(timeout_stb), 32'h0);
    end
    cyc(32'h3000, NONSEQ);
    rsp("to.err1", 1'b0, 1'b1);
    chk("to.stb_hi", 32'(timeout_stb), 32'h1);
    cyc(32'h3000, NONSEQ);
    rsp("to.err2", 1'b1, 1'b1);
    chk("to.stb_clr", 32'(timeout_stb), 32'h0);
    cyc(32'h3000, NONSEQ);
    rsp("to.stalled.err1", 1'b0, 1'b1);
    chk("to.stb_once", 32'(timeout_stb), 32'h0);
    bus.S_HREADYOUT[3] = 1'b1;
    cyc(32'h0, IDLE);
    rsp("to.stalled.err2", 1'b1, 1'b1);
    bus.S_HRDATA[96+:32] = 32'h3333_0003;
    cyc(32'h3000, NONSEQ);
    rsp("to.recover.idle", 1'b1, 1'b0);
    cyc(32'h0, IDLE);
    rsp("to.recover", 1'b1, 1'b0);
    chk("to.recover.HRDATA", bus.HRDATA, 32'h3333_0003);
`endif
    cyc(32'h0, IDLE);
    rsp("final", 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
